regfile_ctx_ctrl: RTL
=====================

// Module: regfile_ctx_ctrl
// PURPOSE
//   Context save/restore sequencer for the 16x4 register file.
//   In IDLE it passes core register-file accesses straight through.
//   On save_req it streams the 8 register pairs into an external LIFO save RAM.
//   On restore_req it streams the newest saved context back into the register file.
//   The core is stalled throughout. Used for interrupt entry/exit and subroutine context nesting.
// PARAMETERS
//   CTX_DEPTH  4  number of context slots in save RAM (power of 2, >=2)
//   MEM_AW     5  save RAM address width = log2(CTX_DEPTH)+3
//   DEPTH_W    3  width of depth output = log2(CTX_DEPTH)+1
// PORTS
//   clk             in   1        clock
//   rst_n           in   1        async reset, active low
//   core_reg_addr   in   4        core single-reg address
//   core_reg_wdata  in   4        core single-reg write data
//   core_reg_we     in   1        core single-reg write enable
//   core_pair_addr  in   3        core pair address
//   core_pair_wdata in   8        core pair write data
//   core_pair_we    in   1        core pair write enable
//   core_stall      out  1        core must hold; its writes are blocked
//   save_req        in   1        request context save (sampled in IDLE only)
//   restore_req     in   1        request context restore (sampled in IDLE only)
//   done            out  1        1-cycle pulse: save/restore finished
//   err             out  1        1-cycle pulse: overflow/underflow/conflict
//   depth           out  DEPTH_W  number of valid saved contexts
//   rf_reg_addr/rf_reg_wdata/rf_reg_we  out 4/4/1  to register file single port
//   rf_pair_addr/rf_pair_wdata/rf_pair_we out 3/8/1 to register file pair port
//   rf_pair_rdata   in   8        pair read data (combinational from RF)
//   mem_addr        out  MEM_AW   save RAM address = {slot, pair}
//   mem_wdata       out  8        save RAM write data
//   mem_we          out  1        save RAM write strobe
//   mem_re          out  1        save RAM read strobe
//   mem_rdata       in   8        read data, valid the cycle after accepted mem_re
//   mem_ready       in   1        RAM accepts the current mem_we/mem_re this cycle
// BEHAVIOUR
//   Reset: state IDLE, cnt=0, depth=0, done=0, err=0, core_stall=0, mem_we=mem_re=0.
//     Reset forces rf_* = core_* pass-through. Reset mid-operation aborts immediately.
//     Saved contexts are discarded logically.
//   States: IDLE, SAVE, RD, WR; 3-bit pair counter cnt.
//   IDLE: rf_* = core_*, mem strobes 0, core_stall=0.
//     save_req&restore_req -> err pulse next cycle, stay IDLE.
//     save_req, depth==CTX_DEPTH -> err, stay. save_req otherwise -> SAVE, cnt=0.
//     restore_req, depth==0 -> err, stay. restore_req otherwise -> RD, cnt=0.
//     A core write in the request cycle still reaches the RF, before the save.
//   SAVE: core_stall=1, core writes blocked (rf_*_we=0).
//     Drives rf_pair_addr=cnt, mem_addr={depth[slot],cnt}, mem_wdata=rf_pair_rdata, mem_we=1.
//     On mem_ready: cnt++. At cnt==7 with mem_ready: depth++, -> IDLE, done=1.
//     mem_ready=0 holds all outputs stable.
//   RD: core_stall=1, mem_re=1, mem_addr={depth-1,cnt}. mem_ready -> WR, else hold.
//   WR: rf_pair_we=1, rf_pair_addr=cnt, rf_pair_wdata=mem_rdata.
//     cnt==7 -> depth--, IDLE, done=1; else cnt++, -> RD.
//   Latency with mem_ready=1: save req at T -> SAVE T+1..T+8, done at T+9.
//     Restore req at T -> done at T+17. Stall drops in the done cycle.
//   done and err are registered pulses, never both high.
//   Requests outside IDLE are ignored, not queued.
//   LIFO: save uses slot=depth, restore uses slot=depth-1. Pair p maps to mem offset p.
// TESTING
//   1 Core writes pairs 0..7=0x10..0x17; save_req@T -> mem_we addr 0..7 data 0x10..0x17, done@T+9, depth=1.
//   2 Core overwrites all pairs to 0xFF; restore_req@T -> RF pairs 0x10..0x17, done@T+17, depth=0.
//   3 4 saves then 5th save_req -> err pulse, depth=4, no mem_we; at depth 0 restore_req -> err.
//   4 mem_ready low 3 cycles mid-save -> mem_addr/wdata held, done 3 cycles late; core_reg_we blocked.
//   5 save_req&restore_req same cycle -> err, no state change; rst_n low mid-restore -> IDLE, depth=0, stall=0 at once.
//   6 Save ctx A (0x2x), save ctx B (0x3x), restore -> B contents, restore -> A contents (LIFO).

Source files
------------

// File: rtl/regfile_ctx_ctrl_if.sv
// Signal bundle between the context sequencer, the core, the register file and the save RAM.
// The slave modport is the sequencer's view; master is the surrounding system.
interface regfile_ctx_ctrl_if #(
    parameter int MEM_AW  = 5,
    parameter int DEPTH_W = 3
);
    logic [3:0]         core_reg_addr;
    logic [3:0]         core_reg_wdata;
    logic               core_reg_we;
    logic [2:0]         core_pair_addr;
    logic [7:0]         core_pair_wdata;
    logic               core_pair_we;
    logic               core_stall;
    logic               save_req;
    logic               restore_req;
    logic               done;
    logic               err;
    logic [DEPTH_W-1:0] depth;
    logic [3:0]         rf_reg_addr;
    logic [3:0]         rf_reg_wdata;
    logic               rf_reg_we;
    logic [2:0]         rf_pair_addr;
    logic [7:0]         rf_pair_wdata;
    logic               rf_pair_we;
    logic [7:0]         rf_pair_rdata;
    logic [MEM_AW-1:0]  mem_addr;
    logic [7:0]         mem_wdata;
    logic               mem_we;
    logic               mem_re;
    logic [7:0]         mem_rdata;
    logic               mem_ready;

    modport slave (
        input  core_reg_addr, core_reg_wdata, core_reg_we,
        input  core_pair_addr, core_pair_wdata, core_pair_we,
        input  save_req, restore_req, rf_pair_rdata, mem_rdata, mem_ready,
        output core_stall, done, err, depth,
        output rf_reg_addr, rf_reg_wdata, rf_reg_we,
        output rf_pair_addr, rf_pair_wdata, rf_pair_we,
        output mem_addr, mem_wdata, mem_we, mem_re
    );

    modport master (
        output core_reg_addr, core_reg_wdata, core_reg_we,
        output core_pair_addr, core_pair_wdata, core_pair_we,
        output save_req, restore_req, rf_pair_rdata, mem_rdata, mem_ready,
        input  core_stall, done, err, depth,
        input  rf_reg_addr, rf_reg_wdata, rf_reg_we,
        input  rf_pair_addr, rf_pair_wdata, rf_pair_we,
        input  mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/regfile_ctx_ctrl.sv
// Context save/restore sequencer: streams the 8 register pairs to/from a LIFO save RAM
// while stalling the core, and passes core register-file accesses through when idle.
module regfile_ctx_ctrl #(
    parameter int CTX_DEPTH = 4,
    parameter int MEM_AW    = $clog2(CTX_DEPTH) + 3,
    parameter int DEPTH_W   = $clog2(CTX_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    regfile_ctx_ctrl_if.slave bus
);
    localparam int SLOT_W = MEM_AW - 3;

    typedef enum logic [1:0] {IDLE, SAVE, RD, WR} state_t;

    state_t             state_q;
    logic [2:0]         cnt_q;
    logic [DEPTH_W-1:0] depth_q;
    logic               done_q;
    logic               err_q;
    logic [SLOT_W-1:0]  wrSlot;
    logic [SLOT_W-1:0]  rdSlot;

    // Saves push onto slot depth, restores pop from slot depth-1.
    assign wrSlot = depth_q[SLOT_W-1:0];
    assign rdSlot = SLOT_W'(depth_q - DEPTH_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            depth_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.save_req && bus.restore_req) begin
                        err_q <= 1'b1;
                    end else if (bus.save_req) begin
                        if (depth_q == DEPTH_W'(CTX_DEPTH)) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q <= SAVE;
                            cnt_q   <= '0;
                        end
                    end else if (bus.restore_req) begin
                        if (depth_q == '0) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q <= RD;
                            cnt_q   <= '0;
                        end
                    end
                end
                SAVE: begin
                    if (bus.mem_ready) begin
                        if (cnt_q == 3'd7) begin
                            depth_q <= depth_q + DEPTH_W'(1);
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 3'd1;
                        end
                    end
                end
                RD: begin
                    if (bus.mem_ready) begin
                        state_q <= WR;
                    end
                end
                WR: begin
                    if (cnt_q == 3'd7) begin
                        depth_q <= depth_q - DEPTH_W'(1);
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + 3'd1;
                        state_q <= RD;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Core writes only reach the register file while idle; the sequencer owns the pair port otherwise.
    always_comb begin
        bus.rf_reg_addr   = bus.core_reg_addr;
        bus.rf_reg_wdata  = bus.core_reg_wdata;
        bus.rf_reg_we     = 1'b0;
        bus.rf_pair_addr  = bus.core_pair_addr;
        bus.rf_pair_wdata = bus.core_pair_wdata;
        bus.rf_pair_we    = 1'b0;
        bus.mem_addr      = '0;
        bus.mem_wdata     = '0;
        bus.mem_we        = 1'b0;
        bus.mem_re        = 1'b0;
        case (state_q)
            IDLE: begin
                bus.rf_reg_we  = bus.core_reg_we;
                bus.rf_pair_we = bus.core_pair_we;
            end
            SAVE: begin
                bus.rf_pair_addr = cnt_q;
                bus.mem_addr     = {wrSlot, cnt_q};
                bus.mem_wdata    = bus.rf_pair_rdata;
                bus.mem_we       = 1'b1;
            end
            RD: begin
                bus.rf_pair_addr = cnt_q;
                bus.mem_addr     = {rdSlot, cnt_q};
                bus.mem_re       = 1'b1;
            end
            WR: begin
                bus.rf_pair_addr  = cnt_q;
                bus.rf_pair_wdata = bus.mem_rdata;
                bus.rf_pair_we    = 1'b1;
                bus.mem_addr      = {rdSlot, cnt_q};
            end
            default: ;
        endcase
    end

    assign bus.core_stall = (state_q != IDLE);
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.depth      = depth_q;
endmodule
